// File: rtl/merger_leaf_feeder.sv
// merger_leaf_feeder
//   Producer-side feeder for the merger tree. Splits one sorted record stream
//   into runs of RUN_LEN records, appends an all-zero terminator to each run
//   and writes the runs round-robin into the 2*L leaf FIFOs (leaf 0 first).
//
// Ports
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_data/i_valid  input record stream; o_ready accepts when both high
//   i_flush         single-cycle pulse closing the current run early
//   i_fifo_full     full flags of the leaf FIFOs
//   o_fifo_write    one-hot enqueue strobes (combinational, zero latency)
//   o_fifo_data     shared enqueue data bus
//   o_leaf          current target leaf
//   o_runs_done     terminators written, wraps modulo 2^16
//   o_zero_err      sticky flag: a zero record was remapped
//
// Optional feature
//   MERGER_FEEDER_ZERO_CHECK_EN: accepted zero records are written as 1 so
//   they cannot alias the terminator, and o_zero_err latches. Without the
//   macro records pass unmodified and o_zero_err is tied low.
module merger_leaf_feeder #(
  parameter int L          = 32,
  parameter int DATA_WIDTH = 128,
  parameter int RUN_LEN    = 16
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_WIDTH-1:0]     i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_flush,
  input  logic [2*L-1:0]            i_fifo_full,
  output logic [2*L-1:0]            o_fifo_write,
  output logic [DATA_WIDTH-1:0]     o_fifo_data,
  output logic [$clog2(2*L)-1:0]    o_leaf,
  output logic [15:0]               o_runs_done,
  output logic                      o_zero_err
);

  localparam int NUM_LEAVES = 2 * L;
  localparam int LEAF_W     = $clog2(NUM_LEAVES);

  typedef enum logic {
    ST_LOAD,
    ST_TERM
  } state_t;

  state_t             state_q, state_d;
  logic [LEAF_W-1:0]  leaf_q, leaf_d;
  logic [15:0]        rec_cnt_q, rec_cnt_d;
  logic [15:0]        runs_done_q, runs_done_d;
  logic               flush_pend_q, flush_pend_d;

  logic               leaf_free;
  logic               load_ready;
  logic               accept;
  logic               term_write;

  assign leaf_free  = ~i_fifo_full[leaf_q];
  // Gating with i_rst_n keeps the strobes low the moment reset asserts,
  // even though the strobes are purely combinational.
  assign load_ready = i_rst_n & (state_q == ST_LOAD) & leaf_free & ~flush_pend_q;
  assign accept     = i_valid & load_ready;
  assign term_write = i_rst_n & (state_q == ST_TERM) & leaf_free;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_LOAD;
      leaf_q       <= '0;
      rec_cnt_q    <= '0;
      runs_done_q  <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      leaf_q       <= leaf_d;
      rec_cnt_q    <= rec_cnt_d;
      runs_done_q  <= runs_done_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d      = state_q;
    leaf_d       = leaf_q;
    rec_cnt_d    = rec_cnt_q;
    runs_done_d  = runs_done_q;
    flush_pend_d = flush_pend_q;
    unique case (state_q)
      ST_LOAD: begin
        if (accept) begin
          rec_cnt_d = rec_cnt_q + 16'd1;
        end
        // Flush only closes a non-empty run; a same-cycle accept still lands.
        if (i_flush && (rec_cnt_q != 16'd0)) begin
          flush_pend_d = 1'b1;
        end
        if ((accept && (rec_cnt_q + 16'd1 == 16'(RUN_LEN))) || flush_pend_d) begin
          state_d = ST_TERM;
        end
      end
      ST_TERM: begin
        if (leaf_free) begin
          state_d      = ST_LOAD;
          rec_cnt_d    = '0;
          flush_pend_d = 1'b0;
          runs_done_d  = runs_done_q + 16'd1;
          leaf_d       = (leaf_q == LEAF_W'(NUM_LEAVES - 1)) ? '0 : leaf_q + LEAF_W'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  // Output decode: strobes and data follow the current state with no delay
  always_comb begin
    o_ready      = load_ready;
    o_fifo_write = '0;
    o_fifo_data  = '0;
    if (accept) begin
      o_fifo_write[leaf_q] = 1'b1;
`ifdef MERGER_FEEDER_ZERO_CHECK_EN
      o_fifo_data = (i_data == '0) ? DATA_WIDTH'(1) : i_data;
`else
      o_fifo_data = i_data;
`endif
    end else if (term_write) begin
      o_fifo_write[leaf_q] = 1'b1;
      o_fifo_data          = '0;
    end
  end

  assign o_leaf      = leaf_q;
  assign o_runs_done = runs_done_q;

`ifdef MERGER_FEEDER_ZERO_CHECK_EN
  logic zero_err_q, zero_err_d;

  always_comb begin
    zero_err_d = zero_err_q;
    if (accept && (i_data == '0)) begin
      zero_err_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      zero_err_q <= 1'b0;
    end else begin
      zero_err_q <= zero_err_d;
    end
  end

  assign o_zero_err = zero_err_q;
`else
  assign o_zero_err = 1'b0;
`endif

endmodule

// File: tb/tb_merger_leaf_feeder.sv
// Testbench for merger_leaf_feeder: drives the record stream, captures every
// leaf write into per-leaf queues and compares them against per-leaf queues
// built from the run rules (fixed run length, early flush, round-robin).
module tb_merger_leaf_feeder;
  localparam int L  = 32;
  localparam int DW = 128;
  localparam int RL = 16;
  localparam int NL = 2 * L;
  localparam int LW = $clog2(NL);

  logic            i_clk = 1'b0;
  logic            i_rst_n;
  logic [DW-1:0]   i_data;
  logic            i_valid;
  logic            o_ready;
  logic            i_flush;
  logic [NL-1:0]   i_fifo_full;
  logic [NL-1:0]   o_fifo_write;
  logic [DW-1:0]   o_fifo_data;
  logic [LW-1:0]   o_leaf;
  logic [15:0]     o_runs_done;
  logic            o_zero_err;

  merger_leaf_feeder #(.L(L), .DATA_WIDTH(DW), .RUN_LEN(RL)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_flush      (i_flush),
    .i_fifo_full  (i_fifo_full),
    .o_fifo_write (o_fifo_write),
    .o_fifo_data  (o_fifo_data),
    .o_leaf       (o_leaf),
    .o_runs_done  (o_runs_done),
    .o_zero_err   (o_zero_err)
  );

  always #5 i_clk = ~i_clk;

  int checks      = 0;
  int errors      = 0;
  int strobeCount = 0;
  int runsClosed  = 0;

  logic [DW-1:0] obsQ [NL][$];
  logic [DW-1:0] expQ [NL][$];
  logic [DW-1:0] curRun [$];

`ifdef MERGER_FEEDER_ZERO_CHECK_EN
  localparam bit ZERO_CHECK = 1'b1;
`else
  localparam bit ZERO_CHECK = 1'b0;
`endif

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DW-1:0] adj(input logic [DW-1:0] d);
    if (ZERO_CHECK && d == '0) return DW'(1);
    return d;
  endfunction

  function automatic logic [NL-1:0] randFullVec();
    logic [NL-1:0] a, b;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    return a & b;
  endfunction

  // Reference model: a run closes after RL records or on a flush of a
  // non-empty run; closed runs land on leaf (run number mod NL) plus a zero.
  task automatic closeRun();
    int l;
    l = runsClosed % NL;
    foreach (curRun[i]) expQ[l].push_back(curRun[i]);
    expQ[l].push_back('0);
    runsClosed++;
    curRun.delete();
  endtask

  task automatic noteRecord(input logic [DW-1:0] d);
    curRun.push_back(adj(d));
    if (curRun.size() == RL) closeRun();
  endtask

  task automatic noteFlush();
    if (curRun.size() > 0) closeRun();
  endtask

  task automatic clearModel();
    for (int l = 0; l < NL; l++) begin
      obsQ[l].delete();
      expQ[l].delete();
    end
    curRun.delete();
    runsClosed = 0;
  endtask

  // Called just after a falling edge with inputs set; samples what the next
  // rising edge will commit, then advances to the following falling edge.
  task automatic stepCycle(output bit acc);
    int idx;
    idx = -1;
    #1;
    checkOutput("strobe_onehot", DW'($countones(o_fifo_write) > 1), '0);
    checkOutput("write_to_full", DW'(|(o_fifo_write & i_fifo_full)), '0);
    if (i_fifo_full[o_leaf]) checkOutput("ready_when_full", DW'(o_ready), '0);
    for (int i = 0; i < NL; i++) if (o_fifo_write[i]) idx = i;
    if (idx >= 0) begin
      obsQ[idx].push_back(o_fifo_data);
      strobeCount++;
    end
    acc = i_valid && o_ready;
    if (acc) begin
      checkOutput("accept_strobe_leaf", DW'(o_fifo_write[o_leaf]), DW'(1));
      checkOutput("accept_data", o_fifo_data, adj(i_data));
    end
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_fifo_full = '0;
    for (int k = 0; k < n; k++) stepCycle(acc);
  endtask

  task automatic applyStimulus(input logic [DW-1:0] d, input bit doFlush,
                               input bit randFull, input int gapMax);
    bit acc;
    bit fl;
    int tries;
    if (gapMax > 0) idle($urandom_range(0, gapMax));
    i_valid = 1'b1;
    i_data  = d;
    acc     = 1'b0;
    tries   = 0;
    while (!acc && tries < 200) begin
      fl = doFlush && (tries == 0);
      i_flush = fl;
      i_fifo_full = randFull ? randFullVec() : '0;
      stepCycle(acc);
      if (acc) noteRecord(d);
      if (fl) noteFlush();
      tries++;
    end
    i_valid = 1'b0;
    i_flush = 1'b0;
    i_fifo_full = '0;
    if (!acc) checkOutput("accept_timeout", '0, DW'(1));
  endtask

  task automatic pulseFlush();
    bit acc;
    i_valid = 1'b0;
    i_flush = 1'b1;
    i_fifo_full = '0;
    stepCycle(acc);
    noteFlush();
    i_flush = 1'b0;
  endtask

  task automatic checkState(input string tag);
    checkOutput({tag, "_runs_done"}, DW'(o_runs_done), DW'(runsClosed % 65536));
    checkOutput({tag, "_leaf"}, DW'(o_leaf), DW'(runsClosed % NL));
  endtask

  task automatic compareLeaves(input string tag);
    int n;
    for (int l = 0; l < NL; l++) begin
      checkOutput($sformatf("%s_leaf%0d_len", tag, l), DW'(obsQ[l].size()), DW'(expQ[l].size()));
      n = (obsQ[l].size() < expQ[l].size()) ? obsQ[l].size() : expQ[l].size();
      for (int i = 0; i < n; i++)
        checkOutput($sformatf("%s_leaf%0d_rec%0d", tag, l, i), obsQ[l][i], expQ[l][i]);
      obsQ[l].delete();
      expQ[l].delete();
    end
  endtask

  task automatic doReset();
    i_rst_n = 1'b0;
    i_valid = 1'b1;
    i_data  = DW'(9);
    i_flush = 1'b0;
    i_fifo_full = '0;
    @(negedge i_clk);
    #1;
    checkOutput("rst_ready", DW'(o_ready), '0);
    checkOutput("rst_write", DW'(o_fifo_write), '0);
    checkOutput("rst_leaf", DW'(o_leaf), '0);
    checkOutput("rst_runs_done", DW'(o_runs_done), '0);
    checkOutput("rst_zero_err", DW'(o_zero_err), '0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    clearModel();
  endtask

  initial begin
    bit acc;
    int tgt;
    int sc;
    logic [DW-1:0] d;
    bit fl;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_flush = 1'b0;
    i_fifo_full = '0;
    doReset();

    // Two full runs of consecutive records
    strobeCount = 0;
    for (int k = 1; k <= 32; k++) applyStimulus(DW'(k), 1'b0, 1'b0, 0);
    idle(2);
    checkOutput("t1_strobes", DW'(strobeCount), DW'(34));
    checkState("t1");
    compareLeaves("t1");

    // Full flag held on the target leaf mid-run
    for (int k = 0; k < 3; k++) applyStimulus(DW'(100 + k), 1'b0, 1'b0, 0);
    tgt = runsClosed % NL;
    i_valid = 1'b1;
    i_data  = DW'(200);
    i_fifo_full = '0;
    i_fifo_full[tgt] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      sc = strobeCount;
      stepCycle(acc);
      checkOutput("hold_no_accept", DW'(acc), '0);
      checkOutput("hold_no_strobe", DW'(strobeCount - sc), '0);
    end
    applyStimulus(DW'(200), 1'b0, 1'b0, 0);
    applyStimulus(DW'(201), 1'b0, 1'b0, 0);
    pulseFlush();
    idle(2);
    checkState("t2");
    compareLeaves("t2");

    // Early flush, then a flush on an empty run
    for (int k = 0; k < 3; k++) applyStimulus(DW'(300 + k), 1'b0, 1'b0, 0);
    pulseFlush();
    idle(2);
    checkState("t3a");
    pulseFlush();
    idle(2);
    checkState("t3b");
    applyStimulus(DW'(400), 1'b0, 1'b0, 0);
    applyStimulus(DW'(401), 1'b1, 1'b0, 0);
    idle(2);
    checkState("t3c");
    compareLeaves("t3");

    // Full wrap through all leaves with random full flags
    doReset();
    for (int k = 0; k < NL * RL; k++)
      applyStimulus({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b1, 0);
    idle(2);
    checkState("t4_wrap");
    applyStimulus(DW'(777), 1'b0, 1'b0, 0);
    pulseFlush();
    idle(2);
    compareLeaves("t4");

    // Random stream with random gaps, stalls and flushes
    for (int k = 0; k < 500; k++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      fl = (curRun.size() > 0) && ($urandom_range(0, 9) == 0);
      if (!fl && $urandom_range(0, 15) == 0) pulseFlush();
      else applyStimulus(d, fl, 1'b1, 2);
    end
    pulseFlush();
    idle(3);
    checkState("t5");
    compareLeaves("t5");

    // Zero record handling
    applyStimulus('0, 1'b0, 1'b0, 0);
    idle(1);
    checkOutput("zero_err_set", DW'(o_zero_err), DW'(ZERO_CHECK));
    applyStimulus(DW'(5), 1'b0, 1'b0, 0);
    pulseFlush();
    idle(2);
    checkOutput("zero_err_sticky", DW'(o_zero_err), DW'(ZERO_CHECK));
    compareLeaves("t6");

    // Reset asserted while a strobe is high drops it at once
    i_valid = 1'b1;
    i_data  = DW'(7);
    i_fifo_full = '0;
    #1;
    checkOutput("pre_reset_write", DW'(o_fifo_write[o_leaf]), DW'(1));
    #1;
    i_rst_n = 1'b0;
    #1;
    checkOutput("async_drop_write", DW'(o_fifo_write), '0);
    checkOutput("async_drop_ready", DW'(o_ready), '0);
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rst_n = 1'b1;
    clearModel();

    // Reset while stalled in the terminator state on a full leaf
    for (int k = 0; k < RL; k++) applyStimulus(DW'(500 + k), 1'b0, 1'b0, 0);
    i_fifo_full = '1;
    stepCycle(acc);
    stepCycle(acc);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("term_rst_write", DW'(o_fifo_write), '0);
    checkOutput("term_rst_leaf", DW'(o_leaf), '0);
    checkOutput("term_rst_runs", DW'(o_runs_done), '0);
    checkOutput("term_rst_zero_err", DW'(o_zero_err), '0);
    @(negedge i_clk);
    i_fifo_full = '0;
    i_rst_n = 1'b1;
    clearModel();
    checkState("t7_after_reset");
    applyStimulus(DW'(55), 1'b0, 1'b0, 0);
    pulseFlush();
    idle(2);
    checkState("t7");
    compareLeaves("t7");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
